// File: rtl/i2s_pkg.sv
// i2s_pkg: frame geometry and defaults shared by the I2S transmitter and receiver.
//   SLOTS_PER_FRAME   - BCLK periods per stereo frame
//   SLOT_BITS         - slots per channel half-frame
//   DEFAULT_BCLK_HALF - audio_clk cycles per BCLK half-period (98.304 MHz -> 3.072 MHz)
package i2s_pkg;

  localparam int unsigned SLOTS_PER_FRAME   = 64;
  localparam int unsigned SLOT_BITS         = 32;
  localparam int unsigned DEFAULT_BCLK_HALF = 16;
  localparam int unsigned SLOT_CNT_W        = $clog2(SLOTS_PER_FRAME);

  typedef logic [SLOT_CNT_W-1:0] slot_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk into a 50% duty BCLK of period 2*BCLK_HALF cycles.
//   clk, rst_n - clock, asynchronous active-low reset
//   bclk       - registered bit clock (0 in reset)
//   rise_c     - high on the cycle whose edge drives bclk 0->1
//   fall_c     - high on the cycle whose edge drives bclk 1->0
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_HALF = DEFAULT_BCLK_HALF
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DIV_W-1:0] div;
  logic             tc_c;

  assign tc_c   = (div == DIV_W'(BCLK_HALF - 1));
  assign rise_c = tc_c & ~bclk;
  assign fall_c = tc_c & bclk;

  // Half-period divider; bclk toggles at each terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (tc_c) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: standard I2S stereo transmitter, 64 slots per frame, MSB first with
// one-bit delay, one-pair pending buffer in front of the shifting pair.
//   audio_clk, rst_in_n        - clock, asynchronous active-low reset
//   left_in, right_in          - signed stereo sample pair
//   sample_valid_in/_ready_out - pair handshake (ready = pending buffer empty)
//   i2s_bclk, i2s_lrclk        - bit clock, word select (0 = left)
//   i2s_dout                   - serial data, changes on BCLK falling edge
//   frame_start_out            - one-cycle pulse when slot 0 begins
//   underrun_out               - one-cycle pulse when a frame starts without data
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_HALF    = DEFAULT_BCLK_HALF,
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                    audio_clk,
  input  logic                    rst_in_n,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_dout,
  output logic                    frame_start_out,
  output logic                    underrun_out
);

  localparam int unsigned IDX_W = $clog2(SAMPLE_WIDTH);

  logic                    bclk_rise_c;
  logic                    bclk_fall_c;
  logic                    load_c;
  slot_t                   slot;
  slot_t                   next_slot_c;
  logic                    bit_next;
  logic [SAMPLE_WIDTH-1:0] pend_l;
  logic [SAMPLE_WIDTH-1:0] pend_r;
  logic [SAMPLE_WIDTH-1:0] act_l;
  logic [SAMPLE_WIDTH-1:0] act_r;

  i2s_bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .clk    (audio_clk),
    .rst_n  (rst_in_n),
    .bclk   (i2s_bclk),
    .rise_c (bclk_rise_c),
    .fall_c (bclk_fall_c)
  );

  // Serial bit for a slot: one-bit delayed MSB-first word in each half-frame.
  function automatic logic slot_bit(input slot_t s,
                                    input logic [SAMPLE_WIDTH-1:0] l,
                                    input logic [SAMPLE_WIDTH-1:0] r);
    logic b;
    b = 1'b0;
    if (s >= slot_t'(1) && s <= slot_t'(SAMPLE_WIDTH))
      b = l[IDX_W'(int'(SAMPLE_WIDTH) - int'(s))];
    else if (s >= slot_t'(SLOT_BITS + 1) && s <= slot_t'(SLOT_BITS + SAMPLE_WIDTH))
      b = r[IDX_W'(int'(SLOT_BITS + SAMPLE_WIDTH) - int'(s))];
    return b;
  endfunction

  assign next_slot_c = slot + slot_t'(1);
  assign load_c      = bclk_fall_c && (slot == slot_t'(SLOTS_PER_FRAME - 1));

  // Pending/active pair handling, slot counter and output shifting.
  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      slot             <= slot_t'(SLOTS_PER_FRAME - 1);
      i2s_lrclk        <= 1'b1;
      i2s_dout         <= 1'b0;
      bit_next         <= 1'b0;
      sample_ready_out <= 1'b1;
      pend_l           <= '0;
      pend_r           <= '0;
      act_l            <= '0;
      act_r            <= '0;
      frame_start_out  <= 1'b0;
      underrun_out     <= 1'b0;
    end else begin
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;

      // Next slot's bit is prepared half a BCLK early, launched on the fall.
      if (bclk_rise_c)
        bit_next <= slot_bit(next_slot_c, act_l, act_r);

      if (load_c) begin
        if (!sample_ready_out) begin
          act_l <= pend_l;
          act_r <= pend_r;
        end else if (sample_valid_in) begin
          act_l <= left_in;
          act_r <= right_in;
        end else begin
          act_l        <= '0;
          act_r        <= '0;
          underrun_out <= 1'b1;
        end
        sample_ready_out <= 1'b1;
        frame_start_out  <= 1'b1;
      end else if (sample_valid_in && sample_ready_out) begin
        pend_l           <= left_in;
        pend_r           <= right_in;
        sample_ready_out <= 1'b0;
      end

      if (bclk_fall_c) begin
        slot      <= next_slot_c;
        i2s_lrclk <= (next_slot_c >= slot_t'(SLOT_BITS));
        i2s_dout  <= bit_next;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed self-checking bench for i2s_tx (BCLK_HALF 16 and 4).
module tb_i2s_tx;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, ready, bclk, lrclk, dout, fs, ur;
  logic [15:0] left, right;
  logic        rst4, valid4, ready4, bclk4, lrclk4, dout4, fs4, ur4;
  logic [15:0] left4, right4;

  int cyc;
  int asserts;
  int fails;

  i2s_tx #(.BCLK_HALF(16), .SAMPLE_WIDTH(16)) dut (
    .audio_clk(clk), .rst_in_n(rst), .left_in(left), .right_in(right),
    .sample_valid_in(valid), .sample_ready_out(ready), .i2s_bclk(bclk),
    .i2s_lrclk(lrclk), .i2s_dout(dout), .frame_start_out(fs), .underrun_out(ur)
  );

  i2s_tx #(.BCLK_HALF(4), .SAMPLE_WIDTH(16)) dut4 (
    .audio_clk(clk), .rst_in_n(rst4), .left_in(left4), .right_in(right4),
    .sample_valid_in(valid4), .sample_ready_out(ready4), .i2s_bclk(bclk4),
    .i2s_lrclk(lrclk4), .i2s_dout(dout4), .frame_start_out(fs4), .underrun_out(ur4)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step(1);
  endtask

  // Reset pulse released on a falling clk edge; cyc counts rising edges from release.
  task automatic do_reset(input bit sel);
    if (sel) rst4 = 1'b0; else rst = 1'b0;
    step(3);
    if (sel) rst4 = 1'b1; else rst = 1'b1;
    cyc = 0;
  endtask

  // Samples one frame mid-slot and rebuilds the words; junk counts bad filler/lrclk slots.
  task automatic capture(input int load, input int h, input bit sel,
                         output logic [15:0] l, output logic [15:0] r, output int junk);
    logic b, w;
    l = '0; r = '0; junk = 0;
    for (int s = 0; s < 64; s++) begin
      step_to(load + 2*h*s + h);
      b = sel ? dout4 : dout;
      w = sel ? lrclk4 : lrclk;
      if (w !== (s >= 32)) junk++;
      if (s >= 1 && s <= 16) l[16-s] = b;
      else if (s >= 33 && s <= 48) r[48-s] = b;
      else if (b !== 1'b0) junk++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rst4 = 1'b0; valid = 1'b0; valid4 = 1'b0;
    left = '0; right = '0; left4 = '0; right4 = '0;
    step(2);
    asserts++; if ({bclk, lrclk, dout, fs, ur, ready} !== 6'b010001) begin fails++;
      $display("FAIL reset_outputs: got %b want 010001", {bclk, lrclk, dout, fs, ur, ready}); end
    asserts++; if ({bclk4, lrclk4, dout4, fs4, ur4, ready4} !== 6'b010001) begin fails++;
      $display("FAIL reset_outputs4: got %b want 010001", {bclk4, lrclk4, dout4, fs4, ur4, ready4}); end
  endtask

  task automatic test_frame();
    logic [15:0] l, r; int junk;
    left = 16'hA5C3; right = 16'h8001; valid = 1'b1;
    do_reset(0);
    step(1);
    asserts++; if (ready !== 1'b0) begin fails++; $display("FAIL frame_accept: ready %b want 0", ready); end
    valid = 1'b0;
    step_to(31);
    asserts++; if (fs !== 1'b0) begin fails++; $display("FAIL frame_fs_early: fs %b want 0", fs); end
    step_to(32);
    asserts++; if ({fs, ur, lrclk, ready} !== 4'b1001) begin fails++;
      $display("FAIL frame_load: fs/ur/lrclk/ready %b want 1001", {fs, ur, lrclk, ready}); end
    step(1);
    asserts++; if (fs !== 1'b0) begin fails++; $display("FAIL frame_fs_pulse: fs %b want 0", fs); end
    capture(32, 16, 0, l, r, junk);
    asserts++; if (l !== 16'hA5C3) begin fails++; $display("FAIL frame_left: got %h want a5c3", l); end
    asserts++; if (r !== 16'h8001) begin fails++; $display("FAIL frame_right: got %h want 8001", r); end
    asserts++; if (junk !== 0) begin fails++; $display("FAIL frame_filler: %0d bad slots want 0", junk); end
  endtask

  task automatic test_underrun();
    logic [15:0] l, r; int junk;
    valid = 1'b0;
    do_reset(0);
    step_to(32);
    asserts++; if ({fs, ur} !== 2'b11) begin fails++; $display("FAIL ur_first: fs/ur %b want 11", {fs, ur}); end
    step(1);
    asserts++; if (ur !== 1'b0) begin fails++; $display("FAIL ur_pulse: ur %b want 0", ur); end
    capture(32, 16, 0, l, r, junk);
    asserts++; if ({l, r} !== 32'h0 || junk !== 0) begin fails++;
      $display("FAIL ur_silence: words %h bad %0d want 0 and 0", {l, r}, junk); end
    step_to(2079);
    asserts++; if ({ur, lrclk} !== 2'b01) begin fails++; $display("FAIL ur_before2: ur/lrclk %b want 01", {ur, lrclk}); end
    step_to(2080);
    asserts++; if ({fs, ur, lrclk} !== 3'b110) begin fails++;
      $display("FAIL ur_second: fs/ur/lrclk %b want 110", {fs, ur, lrclk}); end
    step_to(4127);
    asserts++; if (ur !== 1'b0) begin fails++; $display("FAIL ur_before3: ur %b want 0", ur); end
    step_to(4128);
    asserts++; if (ur !== 1'b1) begin fails++; $display("FAIL ur_third: ur %b want 1", ur); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] l, r; int junk;
    valid = 1'b0;
    do_reset(0);
    step_to(100);
    left = 16'h1234; right = 16'h5678; valid = 1'b1;
    step(1);
    asserts++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_first_accept: ready %b want 0", ready); end
    left = 16'h9ABC; right = 16'hDEF0;
    step_to(1000);
    asserts++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_hold: ready %b want 0", ready); end
    step_to(2080);
    asserts++; if ({fs, ur, ready} !== 3'b101) begin fails++;
      $display("FAIL b2b_load1: fs/ur/ready %b want 101", {fs, ur, ready}); end
    step(1);
    asserts++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_second_accept: ready %b want 0", ready); end
    valid = 1'b0;
    capture(2080, 16, 0, l, r, junk);
    asserts++; if ({l, r} !== 32'h12345678 || junk !== 0) begin fails++;
      $display("FAIL b2b_frame1: got %h bad %0d want 12345678", {l, r}, junk); end
    step_to(4128);
    asserts++; if ({fs, ur} !== 2'b10) begin fails++; $display("FAIL b2b_load2: fs/ur %b want 10", {fs, ur}); end
    capture(4128, 16, 0, l, r, junk);
    asserts++; if ({l, r} !== 32'h9ABCDEF0 || junk !== 0) begin fails++;
      $display("FAIL b2b_frame2: got %h bad %0d want 9abcdef0", {l, r}, junk); end
  endtask

  task automatic test_bypass();
    logic [15:0] l, r; int junk;
    valid = 1'b0;
    do_reset(0);
    step_to(31);
    left = 16'h7F80; right = 16'hFFFE; valid = 1'b1;
    step(1);
    asserts++; if ({fs, ur, ready} !== 3'b101) begin fails++;
      $display("FAIL bypass_load: fs/ur/ready %b want 101", {fs, ur, ready}); end
    valid = 1'b0;
    capture(32, 16, 0, l, r, junk);
    asserts++; if ({l, r} !== 32'h7F80FFFE || junk !== 0) begin fails++;
      $display("FAIL bypass_frame: got %h bad %0d want 7f80fffe", {l, r}, junk); end
  endtask

  task automatic test_reset_mid();
    left = 16'h0000; right = 16'h0100; valid = 1'b1;
    do_reset(0);
    step(1);
    valid = 1'b0;
    step_to(1000);
    left = 16'hFFFF; right = 16'hFFFF; valid = 1'b1;
    step(1);
    valid = 1'b0;
    asserts++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_pending: ready %b want 0", ready); end
    step_to(1330);
    asserts++; if ({bclk, lrclk, dout} !== 3'b111) begin fails++;
      $display("FAIL mid_slot40: bclk/lrclk/dout %b want 111", {bclk, lrclk, dout}); end
    #2 rst = 1'b0;
    #1;
    asserts++; if ({bclk, lrclk, dout, fs, ur, ready} !== 6'b010001) begin fails++;
      $display("FAIL mid_async_reset: got %b want 010001", {bclk, lrclk, dout, fs, ur, ready}); end
    step(3);
    rst = 1'b1;
    cyc = 0;
    step_to(31);
    asserts++; if (fs !== 1'b0) begin fails++; $display("FAIL mid_fs_early: fs %b want 0", fs); end
    step_to(32);
    asserts++; if ({fs, ur} !== 2'b11) begin fails++;
      $display("FAIL mid_discard: fs/ur %b want 11", {fs, ur}); end
  endtask

  task automatic test_half4();
    logic [15:0] l, r; int junk;
    left4 = 16'hA5C3; right4 = 16'h8001; valid4 = 1'b1;
    do_reset(1);
    step(1);
    asserts++; if (ready4 !== 1'b0) begin fails++; $display("FAIL h4_accept: ready %b want 0", ready4); end
    valid4 = 1'b0;
    step_to(3);
    asserts++; if (bclk4 !== 1'b0) begin fails++; $display("FAIL h4_bclk3: %b want 0", bclk4); end
    step_to(4);
    asserts++; if (bclk4 !== 1'b1) begin fails++; $display("FAIL h4_bclk4: %b want 1", bclk4); end
    step_to(7);
    asserts++; if ({bclk4, fs4} !== 2'b10) begin fails++; $display("FAIL h4_bclk7: bclk/fs %b want 10", {bclk4, fs4}); end
    step_to(8);
    asserts++; if ({bclk4, fs4, ur4} !== 3'b010) begin fails++;
      $display("FAIL h4_load: bclk/fs/ur %b want 010", {bclk4, fs4, ur4}); end
    capture(8, 4, 1, l, r, junk);
    asserts++; if ({l, r} !== 32'hA5C38001 || junk !== 0) begin fails++;
      $display("FAIL h4_frame: got %h bad %0d want a5c38001", {l, r}, junk); end
    step_to(519);
    asserts++; if (fs4 !== 1'b0) begin fails++; $display("FAIL h4_fs519: %b want 0", fs4); end
    step_to(520);
    asserts++; if ({fs4, ur4} !== 2'b11) begin fails++; $display("FAIL h4_frame2: fs/ur %b want 11", {fs4, ur4}); end
  endtask

  initial begin
    cyc = 0; asserts = 0; fails = 0;
    test_reset();
    test_frame();
    test_underrun();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    test_half4();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter BCLK_HALF, default 16, audio_clk cycles per BCLK half-period (98.304 MHz / 32 = 3.072 MHz BCLK, 48 kHz frame).
REQ-002 Parameter SAMPLE_WIDTH, default 16, bits per channel word, legal range 8..31.
REQ-003 audio_clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_in_n  input  1  asynchronous, active-low reset.
REQ-005 left_in  input  SAMPLE_WIDTH  signed left-channel sample.
REQ-006 right_in  input  SAMPLE_WIDTH  signed right-channel sample.
REQ-007 sample_valid_in  input  1  stereo pair on left_in/right_in is offered.
REQ-008 sample_ready_out  output  1  block accepts a pair this cycle.
REQ-009 i2s_bclk  output  1  serial bit clock to DAC.
REQ-010 i2s_lrclk  output  1  word select; 0 = left, 1 = right.
REQ-011 i2s_dout  output  1  serial data, MSB first.
REQ-012 frame_start_out  output  1  one-cycle pulse when a new frame (slot 0) begins.
REQ-013 underrun_out  output  1  one-cycle pulse when a frame starts with no pair available.

Function
REQ-014 Divider counts 0..BCLK_HALF-1; at terminal count i2s_bclk toggles, giving BCLK period 2*BCLK_HALF cycles, 50% duty.
REQ-015 Frame = 64 slots (0..63), one slot per BCLK period; the slot counter advances, wrapping 63->0, on the cycle i2s_bclk goes 1->0.
REQ-016 i2s_lrclk, i2s_dout and frame_start_out update only on the BCLK falling-edge cycle; stable while i2s_bclk is high.
REQ-017 i2s_lrclk = 0 for slots 0..31 and 1 for slots 32..63.
REQ-018 i2s_dout: slot s in 1..SAMPLE_WIDTH = left bit [SAMPLE_WIDTH-s]; slot s in 33..32+SAMPLE_WIDTH = right bit [32+SAMPLE_WIDTH-s]; all other slots 0 (standard I2S one-bit delay).
REQ-019 Handshake: transfer occurs on a cycle with sample_valid_in && sample_ready_out; sample_ready_out = pending buffer empty.
REQ-020 Pending buffer: one stereo pair deep, so one pair may be accepted while the active pair shifts out.
REQ-021 On the falling-edge cycle entering slot 0 (load cycle), pending moves to the active register and pending clears; frame_start_out pulses.
REQ-022 Load cycle with pending empty and sample_valid_in high: the input pair bypasses directly into active, counts as a transfer, and no underrun is signalled.
REQ-023 Load cycle with pending empty and sample_valid_in low: active cleared to zero, frame transmits silence, and underrun_out pulses together with frame_start_out.
REQ-024 Active register is never modified outside the load cycle; samples offered mid-frame never corrupt the frame in progress.
REQ-025 Signed values are transmitted as raw two's-complement bits; no scaling or saturation.

Reset
REQ-026 While rst_in_n = 0: divider 0, i2s_bclk 0, slot counter 63, i2s_lrclk 1, i2s_dout 0, pending empty, active 0, frame_start_out 0, underrun_out 0.
REQ-027 After release, first falling edge occurs 2*BCLK_HALF cycles later and is a load cycle for slot 0.
REQ-028 Reset asserted mid-frame aborts the frame immediately, discards the pending and active pairs, and produces no partial-word pulses.

Structure
REQ-029 Shared package i2s_pkg holds SLOTS_PER_FRAME = 64, SLOT_BITS = 32, and the default BCLK_HALF, shared with the i2s receiver.
REQ-030 One sub-module, i2s_bclk_gen, produces i2s_bclk plus single-cycle rise and fall strobes; the remaining logic (pending/active registers, slot counter, data mux) stays in i2s_tx.

Verification
REQ-031 Reset release, pair L=16'hA5C3, R=16'h8001 valid before first load -> slot 1..16 dout = 1010_0101_1100_0011, slot 33..48 = 1000_0000_0000_0001, others 0, frame_start_out at cycle 32.
REQ-032 sample_valid_in held low -> underrun_out pulses every 2048 cycles, i2s_dout stays 0, lrclk period 2048 cycles.
REQ-033 Two pairs back-to-back mid-frame -> first accepted, ready then 0 until the next load, second accepted after it, transmission order preserved.
REQ-034 Pair asserted exactly on the load cycle with pending empty -> transmitted in that frame, no underrun pulse.
REQ-035 rst_in_n pulsed low at slot 40 -> outputs return to reset values asynchronously, and the first post-reset frame begins 32 cycles after release.
REQ-036 BCLK_HALF = 4 -> BCLK period 8 cycles, frame 512 cycles, and the bit pattern matches REQ-031.
